// File: rtl/output_mem_reader_pkg.sv
// Shared types and default sizing for the output-memory reader.
// The reader streams a block of words from a synchronous-read memory.
package out_mem_pkg;

    localparam int ADD_SIZE_DEF   = 11;
    localparam int DATA_SIZE_DEF  = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/output_mem_reader_if.sv
// Memory read port plus outgoing valid/ready stream of the output-memory reader.
// "master" is the reader side; "slave" is the memory/downstream side.
interface output_mem_reader_if #(
    parameter int ADD_SIZE  = out_mem_pkg::ADD_SIZE_DEF,
    parameter int DATA_SIZE = out_mem_pkg::DATA_SIZE_DEF
);

    logic                 read_en;
    logic [ADD_SIZE-1:0]  read_address;
    logic [DATA_SIZE-1:0] read_data_out;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_last;

    modport master (
        output read_en, read_address, m_valid, m_data, m_last,
        input  read_data_out, m_ready
    );

    modport slave (
        input  read_en, read_address, m_valid, m_data, m_last,
        output read_data_out, m_ready
    );

endinterface

// File: rtl/output_mem_reader_fifo.sv
// Small synchronous FIFO with occupancy count, used as the reader's output buffer.
// DEPTH must be a power of two so the pointers wrap naturally.
module out_mem_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // A push and a pop in the same cycle cancel out.
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);

endmodule

// File: rtl/output_mem_reader.sv
// Reads length words starting at base_addr from a one-cycle-latency memory and
// streams them out in order, throttling reads so the buffer can never overflow.
module output_mem_reader
    import out_mem_pkg::*;
#(
    parameter int ADD_SIZE   = ADD_SIZE_DEF,
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_SIZE-1:0]  base_addr,
    input  logic [ADD_SIZE:0]    length,
    output logic                 busy,
    output logic                 done,
    output_mem_reader_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADD_SIZE-1:0] ADDR_ONE = 1;
    localparam logic [ADD_SIZE:0]   LEN_ONE  = 1;

    state_t                state_q, state_d;
    logic [ADD_SIZE-1:0]   addr_q, addr_d;
    logic [ADD_SIZE:0]     len_q, len_d;
    logic [ADD_SIZE:0]     issued_q, issued_d;
    logic [ADD_SIZE:0]     sent_q, sent_d;
    logic                  in_flight_q, in_flight_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DATA_SIZE-1:0]  fifo_data;
    logic [CW:0]           occupancy;
    logic                  issue;
    logic                  pop;
    logic                  last_beat;

    // A read is only issued when its data is guaranteed a free buffer slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, in_flight_q};
    assign issue     = (state_q == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign pop       = !fifo_empty && bus.m_ready;
    assign last_beat = (sent_q == len_q - LEN_ONE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        sent_d      = sent_q;
        in_flight_d = issue;
        if (pop) begin
            sent_d = sent_q + LEN_ONE;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_ONE;
                    issued_d = issued_q + LEN_ONE;
                    if (issued_q == len_q - LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            sent_q      <= sent_d;
            in_flight_q <= in_flight_d;
        end
    end

    out_mem_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_flight_q),
        .wr_data (bus.read_data_out),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign bus.read_en      = issue;
    assign bus.read_address = addr_q;
    assign bus.m_valid      = !fifo_empty;
    assign bus.m_data       = fifo_data;
    assign bus.m_last       = !fifo_empty && last_beat;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);

endmodule

// File: tb/tb_output_mem_reader.sv
// Directed bench for output_mem_reader: memory model returns addr+0x100, and
// each scenario task checks the stream, read addresses and done timing.
module tb_output_mem_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] length;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;

    logic [31:0] got_data [$];
    bit          got_last [$];
    int          got_cyc  [$];
    logic [10:0] rd_addr  [$];
    int          rd_cyc   [$];
    int          done_cyc;
    int          occ_viol;
    int          unstable;
    int          issued_n;
    int          accepted_n;

    output_mem_reader_if bus ();

    output_mem_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [10:0] a);
        return 32'(a) + 32'h100;
    endfunction

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.read_en) bus.read_data_out <= ram_word(bus.read_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [10:0] b, input logic [11:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Observes a transfer cycle by cycle (cycle 1 = first cycle after start is sampled).
    task automatic run_transfer(input int ready_mode, input int restart_cyc,
                                input int stop_words, input int max_cyc);
        logic        r;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        rd_addr.delete();  rd_cyc.delete();
        done_cyc = -1; occ_viol = 0; unstable = 0; issued_n = 0; accepted_n = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (bus.read_en) begin
                if (issued_n - accepted_n >= 4) occ_viol++;
                rd_addr.push_back(bus.read_address);
                rd_cyc.push_back(cyc);
                issued_n++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            r = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            bus.m_ready = r;
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
                unstable++;
            if (bus.m_valid && r) begin
                got_data.push_back(bus.m_data);
                got_last.push_back(bus.m_last);
                got_cyc.push_back(cyc);
                accepted_n++;
            end
            prev_stall = bus.m_valid && !r;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (cyc == restart_cyc) begin
                start = 1'b1; base_addr = 11'd100; length = 12'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            if (stop_words > 0 && accepted_n >= stop_words) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.m_ready = 1'b0;
        #2;
        checks++;
        if ({bus.read_en, bus.m_valid, bus.m_last, busy, done} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b, expected 00000", {bus.read_en, bus.m_valid, bus.m_last, busy, done});
        else passes++;
        checks++;
        if (bus.read_address !== 11'd0) $display("[TB] FAIL reset_addr: got %0h, expected 0", bus.read_address);
        else passes++;
        checks++;
        if (bus.m_data !== 32'd0) $display("[TB] FAIL reset_data: got %0h, expected 0", bus.m_data);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.m_ready = 1'b1;
        start_xfer(11'd5, 12'd4);
        checks++;
        if ({bus.read_en, busy} !== 2'b11) $display("[TB] FAIL basic_first_read: got %b, expected 11", {bus.read_en, busy});
        else passes++;
        run_transfer(0, 0, 0, 20);
        checks++;
        if (rd_addr.size() !== 4) $display("[TB] FAIL basic_read_count: got %0d, expected 4", rd_addr.size());
        else passes++;
        for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
            checks++;
            if (rd_addr[i] !== 11'(5 + i) || rd_cyc[i] !== i + 1)
                $display("[TB] FAIL basic_read_%0d: got addr %0d cyc %0d, expected addr %0d cyc %0d", i, rd_addr[i], rd_cyc[i], 5 + i, i + 1);
            else passes++;
        end
        checks++;
        if (got_data.size() !== 4) $display("[TB] FAIL basic_word_count: got %0d, expected 4", got_data.size());
        else passes++;
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 32'h105 + 32'(i) || got_cyc[i] !== 3 + i || got_last[i] !== (i == 3))
                $display("[TB] FAIL basic_word_%0d: got %0h cyc %0d last %0d, expected %0h cyc %0d last %0d",
                         i, got_data[i], got_cyc[i], got_last[i], 32'h105 + 32'(i), 3 + i, (i == 3));
            else passes++;
        end
        checks++;
        if (done_cyc !== 7) $display("[TB] FAIL basic_done_cycle: got %0d, expected 7", done_cyc);
        else passes++;
        tick();
        checks++;
        if ({done, busy} !== 2'b00) $display("[TB] FAIL basic_done_width: got %b, expected 00", {done, busy});
        else passes++;
    endtask

    task automatic test_zero_len();
        bus.m_ready = 1'b1;
        start_xfer(11'h33, 12'd0);
        run_transfer(0, 0, 0, 8);
        checks++;
        if (rd_addr.size() !== 0 || got_data.size() !== 0)
            $display("[TB] FAIL zero_len_activity: got %0d reads %0d words, expected 0 reads 0 words", rd_addr.size(), got_data.size());
        else passes++;
        checks++;
        if (done_cyc !== 1) $display("[TB] FAIL zero_len_done_cycle: got %0d, expected 1", done_cyc);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b0) $display("[TB] FAIL zero_len_done_width: got %b, expected 0", done);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [10:0] exp_a [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        logic [31:0] exp_d [4] = '{32'h8FE, 32'h8FF, 32'h100, 32'h101};
        start_xfer(11'd2046, 12'd4);
        run_transfer(0, 0, 0, 20);
        checks++;
        if (rd_addr.size() !== 4 || got_data.size() !== 4)
            $display("[TB] FAIL wrap_counts: got %0d reads %0d words, expected 4 reads 4 words", rd_addr.size(), got_data.size());
        else passes++;
        for (int i = 0; i < 4 && i < rd_addr.size() && i < got_data.size(); i++) begin
            checks++;
            if (rd_addr[i] !== exp_a[i] || got_data[i] !== exp_d[i])
                $display("[TB] FAIL wrap_%0d: got addr %0d data %0h, expected addr %0d data %0h", i, rd_addr[i], got_data[i], exp_a[i], exp_d[i]);
            else passes++;
        end
        checks++;
        if (done_cyc !== 7) $display("[TB] FAIL wrap_done_cycle: got %0d, expected 7", done_cyc);
        else passes++;
        tick();
    endtask

    task automatic test_backpressure();
        start_xfer(11'd16, 12'd8);
        run_transfer(1, 0, 0, 80);
        checks++;
        if (got_data.size() !== 8 || rd_addr.size() !== 8)
            $display("[TB] FAIL bp_counts: got %0d words %0d reads, expected 8 words 8 reads", got_data.size(), rd_addr.size());
        else passes++;
        for (int i = 0; i < 8 && i < got_data.size() && i < rd_addr.size(); i++) begin
            checks++;
            if (got_data[i] !== 32'h110 + 32'(i) || got_last[i] !== (i == 7) || rd_addr[i] !== 11'(16 + i))
                $display("[TB] FAIL bp_word_%0d: got %0h last %0d addr %0d, expected %0h last %0d addr %0d",
                         i, got_data[i], got_last[i], rd_addr[i], 32'h110 + 32'(i), (i == 7), 16 + i);
            else passes++;
        end
        checks++;
        if (occ_viol !== 0) $display("[TB] FAIL bp_occupancy: got %0d over-issues, expected 0", occ_viol);
        else passes++;
        checks++;
        if (unstable !== 0) $display("[TB] FAIL bp_stall_stable: got %0d changes, expected 0", unstable);
        else passes++;
        checks++;
        if (done_cyc === -1) $display("[TB] FAIL bp_done: got timeout, expected done pulse");
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        start_xfer(11'h20, 12'd8);
        run_transfer(0, 0, 3, 40);
        checks++;
        if (accepted_n !== 3 || done_cyc !== -1)
            $display("[TB] FAIL abort_progress: got %0d words done_cyc %0d, expected 3 words no done", accepted_n, done_cyc);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.read_en, bus.m_valid, bus.m_last, busy, done} !== 5'b0 || bus.read_address !== 11'd0 || bus.m_data !== 32'd0)
            $display("[TB] FAIL abort_outputs: got flags %b addr %0h data %0h, expected all 0",
                     {bus.read_en, bus.m_valid, bus.m_last, busy, done}, bus.read_address, bus.m_data);
        else passes++;
        #2 rst = 1'b1;
        tick();
        start_xfer(11'd0, 12'd2);
        run_transfer(0, 0, 0, 20);
        checks++;
        if (got_data.size() !== 2) $display("[TB] FAIL abort_restart_count: got %0d, expected 2", got_data.size());
        else passes++;
        if (got_data.size() == 2) begin
            checks++;
            if (got_data[0] !== 32'h100 || got_data[1] !== 32'h101 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1)
                $display("[TB] FAIL abort_restart_words: got %0h/%0h last %0d%0d, expected 100/101 last 01",
                         got_data[0], got_data[1], got_last[0], got_last[1]);
            else passes++;
        end
        checks++;
        if (done_cyc === -1) $display("[TB] FAIL abort_restart_done: got timeout, expected done pulse");
        else passes++;
        tick();
    endtask

    task automatic test_start_ignored();
        start_xfer(11'd10, 12'd6);
        run_transfer(0, 2, 0, 30);
        checks++;
        if (rd_addr.size() !== 6 || got_data.size() !== 6)
            $display("[TB] FAIL restart_counts: got %0d reads %0d words, expected 6 reads 6 words", rd_addr.size(), got_data.size());
        else passes++;
        for (int i = 0; i < 6 && i < rd_addr.size() && i < got_data.size(); i++) begin
            checks++;
            if (rd_addr[i] !== 11'(10 + i) || got_data[i] !== 32'h10A + 32'(i) || got_last[i] !== (i == 5))
                $display("[TB] FAIL restart_word_%0d: got addr %0d data %0h last %0d, expected addr %0d data %0h last %0d",
                         i, rd_addr[i], got_data[i], got_last[i], 10 + i, 32'h10A + 32'(i), (i == 5));
            else passes++;
        end
        checks++;
        if (done_cyc === -1) $display("[TB] FAIL restart_done: got timeout, expected done pulse");
        else passes++;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.read_en, bus.m_valid, busy} !== 3'b000)
                $display("[TB] FAIL restart_idle_%0d: got %b, expected 000", k, {bus.read_en, bus.m_valid, busy});
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
